// File: rtl/com_ram_pkg.sv
// Shared types and helpers for the com_tpram read-side controller.
// Holds the controller state encoding and the address wrap helper.
package com_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rd_state_e;

  // Explicit compare so that depths which are not a power of two wrap correctly.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/com_skid_fifo.sv
// Small synchronous FIFO used as the output skid buffer of the read controller.
// Push and pop may happen in the same cycle, including when the FIFO is full.
module com_skid_fifo #(
  parameter  int W  = 33,
  parameter  int D  = 3,
  localparam int CW = $clog2(D + 1),
  localparam int PW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] FULL_CNT = CW'(D);
  localparam logic [PW-1:0] LAST_PTR = PW'(D - 1);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (cnt == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && ((cnt != FULL_CNT) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (!do_push && do_pop) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // The controller's credit rule must never let a push land on a full buffer.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && (cnt == FULL_CNT) && !pop));

endmodule

// File: rtl/com_tpram_rd_ctrl.sv
// Read-side burst controller for com_tpram_reg: issues RAM reads for a command
// and streams the returned words out through a valid/ready skid buffer.
module com_tpram_rd_ctrl
  import com_ram_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int BUF_D = 3;
  localparam int CNT_W = $clog2(BUF_D + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  rd_state_e         state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic              mem_rd_last;
  logic              inflight;
  logic              inflight_last;
  logic [CNT_W-1:0]  buf_cnt;
  logic              buf_empty;
  logic [DATA_W:0]   buf_head;
  logic              pop;
  int                occ;

  assign pop       = out_valid && out_ready;
  assign out_valid = !buf_empty;
  assign out_data  = buf_head[DATA_W-1:0];
  assign out_last  = out_valid && buf_head[DATA_W];

  // Words already owed to the buffer after this edge; the pop term lets the
  // credit loop keep one read per clock with only three buffer slots.
  always_comb begin
    occ = int'(buf_cnt) + int'(inflight) + int'(mem_rd_en) - int'(pop);
  end

  com_skid_fifo #(
    .W (DATA_W + 1),
    .D (BUF_D)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, mem_rd_data}),
    .pop       (pop),
    .pop_data  (buf_head),
    .empty     (buf_empty),
    .cnt       (buf_cnt)
  );

  // RAM data is captured only in the cycle after a read, so the stale value
  // left on rd_data between reads never reaches the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_rd_addr   <= '0;
      mem_rd_last   <= 1'b0;
      len_q         <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= mem_rd_en;
      inflight_last <= mem_rd_en && mem_rd_last;
      mem_rd_en     <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            len_q     <= cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= RUN;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= cmd_addr;
              mem_rd_last <= (cmd_len == LEN_W'(1));
              issued      <= LEN_W'(1);
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RUN: begin
          if (issued == len_q) begin
            state <= DRAIN;
          end else if (occ < BUF_D) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= ADDR_W'(wrap_inc(32'(mem_rd_addr), DEPTH));
            mem_rd_last <= (issued + LEN_W'(1) == len_q);
            issued      <= issued + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_len_legal : assert property (@(posedge clk) disable iff (rst)
    (cmd_valid && cmd_ready) |-> (cmd_len <= MAX_LEN));

endmodule
